// File: rtl/fan_tach.sv
// fan_tach: tach pin synchroniser, deglitch filter, gated edge counter, period meter and sticky stall flag
module fan_tach #(
  parameter int GATE_CNT  = 49999999,
  parameter int FILT_LEN  = 16,
  parameter int STALL_WIN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fan_in,
  input  logic        clr_stall,
  output logic [26:0] rpm_cnt,
  output logic        rpm_vld,
  output logic [26:0] period,
  output logic        period_vld,
  output logic        stall
);
  localparam logic [26:0] GMAX = 27'(GATE_CNT);
  localparam logic [7:0]  FMAX = 8'(FILT_LEN - 1);
  localparam logic [3:0]  SWIN = 4'(STALL_WIN);
  localparam logic [26:0] SAT  = '1;
  logic        s1, s, f, f_d, fall, have_edge, wrap;
  logic [7:0]  fcnt;
  logic [26:0] gcnt, edge_cnt, per_cnt;
  logic [3:0]  zero_win, zw_next;
  always_comb begin
    wrap    = gcnt == GMAX;
    zw_next = (edge_cnt != '0) ? 4'd0 : (zero_win == 4'hf) ? zero_win : zero_win + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 1'b1;
      s          <= 1'b1;
      f          <= 1'b1;
      f_d        <= 1'b1;
      fall       <= 1'b0;
      fcnt       <= '0;
      gcnt       <= '0;
      edge_cnt   <= '0;
      per_cnt    <= '0;
      have_edge  <= 1'b0;
      zero_win   <= '0;
      rpm_cnt    <= '0;
      rpm_vld    <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      stall      <= 1'b0;
    end else begin
      s1         <= fan_in;
      s          <= s1;
      fcnt       <= (s == f || fcnt == FMAX) ? 8'd0 : fcnt + 8'd1;
      f          <= (s != f && fcnt == FMAX) ? ~f : f;
      f_d        <= f;
      fall       <= f_d & ~f;
      gcnt       <= wrap ? 27'd0 : gcnt + 27'd1;
      edge_cnt   <= wrap ? {26'd0, fall} : (fall && edge_cnt != SAT) ? edge_cnt + 27'd1 : edge_cnt;
      rpm_cnt    <= wrap ? edge_cnt : rpm_cnt;
      rpm_vld    <= wrap;
      zero_win   <= wrap ? zw_next : zero_win;
      stall      <= (wrap && zw_next == SWIN) ? 1'b1 : clr_stall ? 1'b0 : stall;
      per_cnt    <= fall ? 27'd1 : (per_cnt != SAT) ? per_cnt + 27'd1 : per_cnt;
      period     <= (fall && have_edge) ? per_cnt : period;
      period_vld <= fall & have_edge;
      have_edge  <= have_edge | fall;
    end
  end
endmodule
